// File: rtl/tppe_pkg.sv
// Shared defaults and FSM state type for the spike fibre packer.
package tppe_pkg;
  localparam int DEF_BITMASK_WIDTH = 128;
  localparam int DEF_TIMESTEPS     = 8;
  localparam int DEF_ADDR_WIDTH    = 8;
  localparam int STATS_WIDTH       = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;
endpackage

// File: rtl/popcount_sat.sv
// Per-train popcount added into a saturating 16-bit accumulator.
// Only compiled when SPIKE_PACKER_STATS_EN is defined.
`ifdef SPIKE_PACKER_STATS_EN
module popcount_sat
  import tppe_pkg::*;
#(
  parameter int W = DEF_TIMESTEPS
) (
  input  logic [W-1:0]             train_i,
  input  logic [STATS_WIDTH-1:0]   acc_i,
  output logic [STATS_WIDTH-1:0]   sum_o
);
  logic [STATS_WIDTH:0] cnt;
  logic [STATS_WIDTH:0] ext;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + (STATS_WIDTH+1)'(train_i[i]);
    end
    ext   = {1'b0, acc_i} + cnt;
    sum_o = ext[STATS_WIDTH] ? {STATS_WIDTH{1'b1}} : ext[STATS_WIDTH-1:0];
  end
endmodule
`endif

// File: rtl/spike_fibre_packer.sv
// Packs per-neuron spike trains into a tile bitmask plus a dense fibre of nonzero trains.
// Optional SPIKE_PACKER_STATS_EN adds a saturating total_spikes counter.
//
// state   | meaning
// COLLECT | accepting neurons, writing nonzero trains to the fibre
// HOLD    | tile complete, presenting bitmask/nnz/base until tile_ready
module spike_fibre_packer
  import tppe_pkg::*;
#(
  parameter int BITMASK_WIDTH = DEF_BITMASK_WIDTH,
  parameter int TIMESTEPS     = DEF_TIMESTEPS,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [TIMESTEPS-1:0]               spike_in,
  input  logic                               spike_valid,
  output logic                               spike_ready,
  input  logic                               flush,
  output logic [BITMASK_WIDTH-1:0]           bitmask_out,
  output logic [$clog2(BITMASK_WIDTH):0]     nnz_count,
  output logic [ADDR_WIDTH-1:0]              tile_base,
  output logic                               tile_valid,
  input  logic                               tile_ready,
  output logic                               fibre_wr_en,
  output logic [ADDR_WIDTH-1:0]              fibre_wr_addr,
`ifdef SPIKE_PACKER_STATS_EN
  output logic [STATS_WIDTH-1:0]             total_spikes,
`endif
  output logic [TIMESTEPS-1:0]               fibre_wr_data
);
  localparam int IW = $clog2(BITMASK_WIDTH);
  localparam int CW = IW + 1;

  state_e                   state_q;
  logic [IW-1:0]            idx_q;
  logic [BITMASK_WIDTH-1:0] bitmask_q;
  logic [CW-1:0]            nnz_q;
  logic [ADDR_WIDTH-1:0]    base_q;

  logic accept;
  logic nonzero;
  logic last_idx;

  assign spike_ready = (state_q == COLLECT);
  assign tile_valid  = (state_q == HOLD);
  // Reset gates acceptance so no fibre write can slip out during rst.
  assign accept      = spike_valid && spike_ready && !rst;
  assign nonzero     = |spike_in;
  assign last_idx    = (idx_q == IW'(BITMASK_WIDTH - 1));

  assign fibre_wr_en   = accept && nonzero;
  assign fibre_wr_addr = base_q + ADDR_WIDTH'(nnz_q);
  assign fibre_wr_data = spike_in;

  assign bitmask_out = bitmask_q;
  assign nnz_count   = nnz_q;
  assign tile_base   = base_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      idx_q     <= '0;
      bitmask_q <= '0;
      nnz_q     <= '0;
      base_q    <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            if (nonzero) begin
              bitmask_q[idx_q] <= 1'b1;
              nnz_q            <= nnz_q + CW'(1);
            end
            idx_q <= idx_q + IW'(1);
            if (last_idx || flush) state_q <= HOLD;
          end else if (flush && (idx_q != '0)) begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (tile_ready) begin
            state_q   <= COLLECT;
            idx_q     <= '0;
            bitmask_q <= '0;
            nnz_q     <= '0;
            base_q    <= base_q + ADDR_WIDTH'(nnz_q);
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

`ifdef SPIKE_PACKER_STATS_EN
  logic [STATS_WIDTH-1:0] total_q;
  logic [STATS_WIDTH-1:0] total_d;

  popcount_sat #(.W(TIMESTEPS)) u_popcount_sat (
    .train_i (spike_in & {TIMESTEPS{accept}}),
    .acc_i   (total_q),
    .sum_o   (total_d)
  );

  always_ff @(posedge clk) begin
    if (rst) total_q <= '0;
    else     total_q <= total_d;
  end

  assign total_spikes = total_q;
`endif
endmodule

// File: tb/tb_spike_fibre_packer.sv
// Directed bench for spike_fibre_packer with a queue-based tile model checked every cycle.
// Define SPIKE_PACKER_STATS_EN to also exercise total_spikes.
module tb_spike_fibre_packer;
  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   spike_in;
  logic         spike_valid;
  logic         spike_ready;
  logic         flush;
  logic [127:0] bitmask_out;
  logic [7:0]   nnz_count;
  logic [7:0]   tile_base;
  logic         tile_valid;
  logic         tile_ready;
  logic         fibre_wr_en;
  logic [7:0]   fibre_wr_addr;
  logic [7:0]   fibre_wr_data;
`ifdef SPIKE_PACKER_STATS_EN
  logic [15:0]  total_spikes;
`endif

  spike_fibre_packer dut (
    .clk           (clk),
    .rst           (rst),
    .spike_in      (spike_in),
    .spike_valid   (spike_valid),
    .spike_ready   (spike_ready),
    .flush         (flush),
    .bitmask_out   (bitmask_out),
    .nnz_count     (nnz_count),
    .tile_base     (tile_base),
    .tile_valid    (tile_valid),
    .tile_ready    (tile_ready),
    .fibre_wr_en   (fibre_wr_en),
    .fibre_wr_addr (fibre_wr_addr),
`ifdef SPIKE_PACKER_STATS_EN
    .total_spikes  (total_spikes),
`endif
    .fibre_wr_data (fibre_wr_data)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model: the current tile is just the list of accepted trains.
  logic [7:0] q_tr[$];
  bit         m_valid = 0;
  bit         m_hold  = 0;
  int         m_base  = 0;
  int         m_total = 0;
  logic [7:0] wlog_a[$];
  logic [7:0] wlog_d[$];

  function automatic logic [127:0] m_mask();
    logic [127:0] r = '0;
    foreach (q_tr[i]) if (q_tr[i] != 8'h00) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int m_nnz();
    int n = 0;
    foreach (q_tr[i]) if (q_tr[i] != 8'h00) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    logic [127:0] emask;
    int           ennz;
    bit           acc;
    emask = m_mask();
    ennz  = m_nnz();
    acc   = spike_valid && !m_hold && !rst;
    if (m_valid) begin
      chk("spike_ready", spike_ready, !m_hold);
      chk("tile_valid", tile_valid, m_hold);
      chk("bitmask_out", bitmask_out, emask);
      chk("nnz_count", nnz_count, ennz);
      chk("tile_base", tile_base, m_base);
      chk("fibre_wr_en", fibre_wr_en, acc && (spike_in != 8'h00));
      if (acc && spike_in != 8'h00) begin
        chk("fibre_wr_addr", fibre_wr_addr, (m_base + ennz) % 256);
        chk("fibre_wr_data", fibre_wr_data, spike_in);
      end
`ifdef SPIKE_PACKER_STATS_EN
      chk("total_spikes", total_spikes, m_total);
`endif
    end
    if (fibre_wr_en === 1'b1) begin
      wlog_a.push_back(fibre_wr_addr);
      wlog_d.push_back(fibre_wr_data);
    end
    if (rst) begin
      m_valid = 1;
      m_hold  = 0;
      q_tr.delete();
      m_base  = 0;
      m_total = 0;
    end else if (!m_hold) begin
      if (acc) begin
        q_tr.push_back(spike_in);
        m_total = m_total + $countones(spike_in);
        if (m_total > 65535) m_total = 65535;
        if (q_tr.size() == 128 || flush) m_hold = 1;
      end else if (flush && q_tr.size() > 0) begin
        m_hold = 1;
      end
    end else if (tile_ready) begin
      m_base = (m_base + ennz) % 256;
      q_tr.delete();
      m_hold = 0;
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic f,
                      input logic tr, input logic r);
    spike_valid = v;
    spike_in    = d;
    flush       = f;
    tile_ready  = tr;
    rst         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wlog_a.delete();
    wlog_d.delete();
  endtask

  task automatic chk_write(input string nm, input int k, input int a, input int d);
    if (wlog_a.size() > k) begin
      chk({nm, "_addr"}, wlog_a[k], a);
      chk({nm, "_data"}, wlog_d[k], d);
    end else begin
      chk({nm, "_missing"}, wlog_a.size(), k + 1);
    end
  endtask

  logic [127:0] exp_mask;
  logic [127:0] held_mask;
  logic [7:0]   d;

  initial begin
    spike_valid = 0; spike_in = 0; flush = 0; tile_ready = 0; rst = 1;
    @(posedge clk);
    #1;
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);

    chk("rst_spike_ready", spike_ready, 1);
    chk("rst_tile_valid", tile_valid, 0);
    chk("rst_nnz", nnz_count, 0);
    chk("rst_base", tile_base, 0);

    // flush on an empty tile must not close it
    step(0, 8'h00, 1, 0, 0);
    chk("empty_flush_ignored", tile_valid, 0);

    // tile 1: nonzero at 0, 5, 127; then stall 10 cycles in HOLD
    clear_log();
    for (int i = 0; i < 128; i++) begin
      d = (i == 0) ? 8'h01 : (i == 5) ? 8'h80 : (i == 127) ? 8'hFF : 8'h00;
      step(1, d, 0, 0, 0);
    end
    exp_mask = '0;
    exp_mask[0] = 1'b1; exp_mask[5] = 1'b1; exp_mask[127] = 1'b1;
    chk("t1_tile_valid", tile_valid, 1);
    chk("t1_bitmask", bitmask_out, exp_mask);
    chk("t1_nnz", nnz_count, 3);
    chk("t1_nwrites", wlog_a.size(), 3);
    chk_write("t1_w0", 0, 0, 8'h01);
    chk_write("t1_w1", 1, 1, 8'h80);
    chk_write("t1_w2", 2, 2, 8'hFF);
    held_mask = bitmask_out;
    for (int i = 0; i < 10; i++) step(1, 8'h3C, (i == 4), 0, 0);
    chk("hold_ready_low", spike_ready, 0);
    chk("hold_mask_stable", bitmask_out, held_mask);
    chk("hold_nnz_stable", nnz_count, 3);
    chk("hold_no_writes", wlog_a.size(), 3);
    step(0, 8'h00, 0, 1, 0);
    chk("t1_next_base", tile_base, 3);
    chk("t1_back_collect", spike_ready, 1);

    // tile 2: flush with the 4th neuron
    clear_log();
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'h11, 1, 0, 0);
    chk("t2_tile_valid", tile_valid, 1);
    chk("t2_bitmask", bitmask_out, 128'h8);
    chk("t2_nnz", nnz_count, 1);
    chk_write("t2_w0", 0, 3, 8'h11);
    step(0, 8'h00, 0, 1, 0);
    chk("t2_next_base", tile_base, 4);

    // walk tile_base up to 254: 128 + 122 nonzero trains
    for (int i = 0; i < 128; i++) step(1, 8'((i % 255) + 1), 0, 0, 0);
    chk("full_tile_closed", tile_valid, 1);
    step(0, 8'h00, 0, 1, 0);
    chk("base_132", tile_base, 132);
    for (int i = 0; i < 122; i++) step(1, 8'h40 | 8'(i & 3), (i == 121), 0, 0);
    step(0, 8'h00, 0, 1, 0);
    chk("base_254", tile_base, 254);

    // tile 3: address wrap
    clear_log();
    for (int i = 0; i < 4; i++) step(1, 8'hA1 + 8'(i), (i == 3), 0, 0);
    chk_write("wrap_w0", 0, 254, 8'hA1);
    chk_write("wrap_w1", 1, 255, 8'hA2);
    chk_write("wrap_w2", 2, 0, 8'hA3);
    chk_write("wrap_w3", 3, 1, 8'hA4);
    step(0, 8'h00, 0, 1, 0);
    chk("wrap_next_base", tile_base, 2);

    // reset mid-tile after 50 neurons
    for (int i = 0; i < 50; i++) step(1, (i % 3 == 0) ? 8'(i + 1) : 8'h00, 0, 0, 0);
    step(1, 8'h77, 0, 0, 1);
    chk("mid_rst_ready", spike_ready, 1);
    chk("mid_rst_valid", tile_valid, 0);
    chk("mid_rst_mask", bitmask_out, 0);
    chk("mid_rst_nnz", nnz_count, 0);
    chk("mid_rst_base", tile_base, 0);
    chk("mid_rst_wr_en", fibre_wr_en, 0);
    clear_log();
    step(1, 8'h00, 0, 0, 0);
    step(1, 8'h5A, 0, 0, 0);
    chk_write("post_rst_w0", 0, 0, 8'h5A);
    step(0, 8'h00, 0, 0, 0);

`ifdef SPIKE_PACKER_STATS_EN
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 8'hFF, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("stats_total_24", total_spikes, 24);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/spike_fibre_packer.md
SPIKE_FIBRE_PACKER -- requirements
Module: spike_fibre_packer

Interface
REQ-001 SHALL have parameter BITMASK_WIDTH, default 128: neurons per output tile.
REQ-002 SHALL have parameter TIMESTEPS, default 8: spike-train width per neuron.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8: fibre memory address width.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port spike_in  input  TIMESTEPS  spike train of the current neuron; bit t is timestep t.
REQ-007 SHALL have port spike_valid  input  1  spike_in is valid.
REQ-008 SHALL have port spike_ready  output  1  packer accepts spike_in.
REQ-009 SHALL have port flush  input  1  close a partial tile early.
REQ-010 SHALL have port bitmask_out  output  BITMASK_WIDTH  bit i set when neuron i has a nonzero train.
REQ-011 SHALL have port nnz_count  output  $clog2(BITMASK_WIDTH)+1  number of set bits in bitmask_out.
REQ-012 SHALL have port tile_base  output  ADDR_WIDTH  fibre address of the tile's first nonzero train.
REQ-013 SHALL have port tile_valid / tile_ready  output / input  1 each  tile handshake.
REQ-014 SHALL have ports fibre_wr_en  output 1, fibre_wr_addr  output ADDR_WIDTH, fibre_wr_data  output TIMESTEPS: packed nonzero-train write port.

Function
REQ-015 SHALL implement states COLLECT and HOLD; spike_ready = (state==COLLECT).
REQ-016 SHALL accept a neuron on spike_valid && spike_ready; neuron index idx counts 0..BITMASK_WIDTH-1 within the tile.
REQ-017 SHALL, for an accepted nonzero spike_in, set bitmask bit idx and, in the same cycle, drive fibre_wr_en=1, fibre_wr_addr=tile_base+nnz (mod 2^ADDR_WIDTH), fibre_wr_data=spike_in (combinational), then increment nnz.
REQ-018 SHALL, for an accepted all-zero spike_in, advance idx only, with no write.
REQ-019 SHALL enter HOLD on the cycle after accepting neuron BITMASK_WIDTH-1, or after flush when idx>0; tile_valid=1 in HOLD.
REQ-020 SHALL, when flush coincides with an accepted neuron, include that neuron, then close the tile.
REQ-021 SHALL ignore flush when idx==0 and no neuron is accepted, and always in HOLD.
REQ-022 SHALL hold bitmask_out, nnz_count and tile_base stable throughout HOLD.
REQ-023 SHALL, on tile_valid && tile_ready, return to COLLECT next cycle with bitmask, idx and nnz cleared, and tile_base += nnz_count, wrapping mod 2^ADDR_WIDTH.
REQ-024 SHALL keep fibre_wr_en low whenever no nonzero neuron is accepted.

Reset
REQ-025 SHALL, on rst (overriding all other inputs), enter COLLECT with bitmask_out=0, nnz_count=0, tile_base=0, idx=0, tile_valid=0, fibre_wr_en=0; spike_ready=1 the cycle after rst deasserts.
REQ-026 SHALL discard a partially collected tile when rst asserts mid-tile or in HOLD.

Configuration
REQ-027 SHALL, with SPIKE_PACKER_STATS_EN defined, add output total_spikes (16 bits), counting all 1 bits of accepted spike_in, saturating at 16'hFFFF, cleared by rst only.
REQ-028 SHALL, without SPIKE_PACKER_STATS_EN, omit the port and counter; all other behaviour identical.

Structure
REQ-029 SHALL place default widths and the state enum (COLLECT, HOLD) in shared package tppe_pkg.
REQ-030 SHALL instantiate one sub-module, popcount_sat, for the REQ-027 per-train popcount with saturating add; it is absent when the macro is undefined.

Verification
REQ-031 SHALL cover 128 neurons, trains nonzero at idx 0, 5, 127 (0x01, 0x80, 0xFF), tile_ready=1 -> writes at addr 0,1,2 with the matching data; tile_valid, bitmask_out bits {0,5,127}, nnz_count=3.
REQ-032 SHALL cover tile_ready=0 for 10 cycles in HOLD -> spike_ready=0, outputs stable; after handshake, next tile_base=3.
REQ-033 SHALL cover flush with the 4th neuron (0x11, accepted) -> tile closes with idx 3 included, bitmask=0x8 (bit 3), nnz_count=1.
REQ-034 SHALL cover tile_base=254 with 4 nonzero neurons -> write addresses 254, 255, 0, 1; next tile_base=2.
REQ-035 SHALL cover rst asserted mid-tile after 50 neurons -> all outputs per REQ-025; the next tile writes from addr 0.
REQ-036 SHALL cover SPIKE_PACKER_STATS_EN with trains 0xFF ×3 -> total_spikes=24.
